tpu_commit_tx: RTL and testbench

Per-TPU commit transmitter; the sending end of the commit path that the commit aggregator receives. It records the issue number of every thread program the MPU broadcasts to its TPU, queues them in order, and emits one commit pulse carrying the matching issue number each time the TPU sequencer reports thread termination. One instance sits inside each TPU, between the instruction-issue input and the O_Term/O_IssueNo outputs.

---
 rtl/pkg_mpu.sv | 6 +
 rtl/pkg_tpu.sv | 9 +
 rtl/tpu_commit_tx_commit_fifo.sv | 65 ++++++
 rtl/tpu_commit_tx.sv | 94 +++++++++
 tb/tb_tpu_commit_tx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pkg_mpu.sv
// MPU-wide shared types: the issue number that tags every broadcast thread program.
package pkg_mpu;

    typedef logic [7:0] mpu_issue_no_t;

endpackage

// File: rtl/pkg_tpu.sv
// TPU-local defaults for the commit transmitter: queue depth, watchdog limit, occupancy type.
package pkg_tpu;

    localparam int unsigned COMMIT_QUEUE_DEPTH    = 8;
    localparam int unsigned COMMIT_TIMEOUT_CYCLES = 1024;

    typedef logic [$clog2(COMMIT_QUEUE_DEPTH+1)-1:0] commit_cnt_t;

endpackage

// File: rtl/tpu_commit_tx_commit_fifo.sv
// commit_fifo: in-order store of outstanding issue numbers with occupancy counter and full/empty flags.
module commit_fifo
    import pkg_mpu::*;
#(
    parameter int unsigned DEPTH = pkg_tpu::COMMIT_QUEUE_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  mpu_issue_no_t                wdata,
    output mpu_issue_no_t                rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    mpu_issue_no_t      mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_nxt;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage has no reset; only the pointers and counter define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            busy  <= (count_nxt != '0);
        end
    end

endmodule

// File: rtl/tpu_commit_tx.sv
// tpu_commit_tx: queues issued thread numbers and emits one commit per thread termination, FIFO order.
// Optional watchdog enabled by macro TPU_COMMIT_TIMEOUT_EN.
module tpu_commit_tx
    import pkg_mpu::*;
#(
    parameter int unsigned DEPTH          = pkg_tpu::COMMIT_QUEUE_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = pkg_tpu::COMMIT_TIMEOUT_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         I_En_Exe,
    input  logic                         I_Req,
    input  mpu_issue_no_t                I_IssueNo,
    output logic                         O_Nack,
    input  logic                         I_Term,
    output logic                         O_Term,
    output mpu_issue_no_t                O_IssueNo,
    output logic                         O_Busy,
    output logic [$clog2(DEPTH+1)-1:0]   O_Count,
    output logic                         O_Err,
    output logic                         O_Timeout
);

    logic          issue;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    mpu_issue_no_t head;

    // Pop is evaluated first so a full queue can still accept a same-cycle push.
    assign issue = I_Req & I_En_Exe;
    assign pop   = I_Term & ~empty;
    assign push  = issue & (~full | pop);

    commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (I_IssueNo),
        .rdata (head),
        .count (O_Count),
        .busy  (O_Busy),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            O_Term    <= 1'b0;
            O_IssueNo <= '0;
            O_Nack    <= 1'b0;
            O_Err     <= 1'b0;
        end else begin
            O_Term <= pop;
            if (pop) begin
                O_IssueNo <= head;
            end
            O_Nack <= issue & full & ~pop;
            if (I_Term && empty) begin
                O_Err <= 1'b1;
            end
        end
    end

`ifdef TPU_COMMIT_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            O_Timeout <= 1'b0;
        end else begin
            if (pop || empty) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_cnt == WD_MAX) begin
                O_Timeout <= 1'b1;
            end
        end
    end
`else
    assign O_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_commit_tx.sv
// Directed self-checking bench for tpu_commit_tx (DEPTH=8, TIMEOUT_CYCLES=16).
module tb_tpu_commit_tx;
    import pkg_mpu::*;

    logic          clock;
    logic          reset;
    logic          I_En_Exe;
    logic          I_Req;
    mpu_issue_no_t I_IssueNo;
    logic          O_Nack;
    logic          I_Term;
    logic          O_Term;
    mpu_issue_no_t O_IssueNo;
    logic          O_Busy;
    logic [3:0]    O_Count;
    logic          O_Err;
    logic          O_Timeout;

    int unsigned n_cmp;
    int unsigned n_err;

    tpu_commit_tx #(
        .DEPTH          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .I_En_Exe  (I_En_Exe),
        .I_Req     (I_Req),
        .I_IssueNo (I_IssueNo),
        .O_Nack    (O_Nack),
        .I_Term    (I_Term),
        .O_Term    (O_Term),
        .O_IssueNo (O_IssueNo),
        .O_Busy    (O_Busy),
        .O_Count   (O_Count),
        .O_Err     (O_Err),
        .O_Timeout (O_Timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        I_Req = 1'b0; I_En_Exe = 1'b0; I_Term = 1'b0; I_IssueNo = '0;
    endtask

    task automatic push(input mpu_issue_no_t v);
        I_Req = 1'b1; I_En_Exe = 1'b1; I_Term = 1'b0; I_IssueNo = v;
        tick();
        idle();
    endtask

    task automatic term_expect(input string tag, input mpu_issue_no_t v);
        I_Term = 1'b1;
        tick();
        I_Term = 1'b0;
        chk({tag, "_term"}, 32'(O_Term), 32'd1);
        chk({tag, "_no"}, 32'(O_IssueNo), 32'(v));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_term",    32'(O_Term),    32'd0);
        chk("rst_no",      32'(O_IssueNo), 32'd0);
        chk("rst_nack",    32'(O_Nack),    32'd0);
        chk("rst_busy",    32'(O_Busy),    32'd0);
        chk("rst_count",   32'(O_Count),   32'd0);
        chk("rst_err",     32'(O_Err),     32'd0);
        chk("rst_timeout", 32'(O_Timeout), 32'd0);
        reset = 1'b1;
        tick();

        // In-order commit of 3..7
        push(8'd3);
        chk("p1_count1", 32'(O_Count), 32'd1);
        chk("p1_busy1",  32'(O_Busy),  32'd1);
        push(8'd4); push(8'd5); push(8'd6); push(8'd7);
        chk("p1_count5", 32'(O_Count), 32'd5);
        term_expect("p1_c0", 8'd3);
        chk("p1_count4", 32'(O_Count), 32'd4);
        term_expect("p1_c1", 8'd4);
        term_expect("p1_c2", 8'd5);
        term_expect("p1_c3", 8'd6);
        term_expect("p1_c4", 8'd7);
        chk("p1_count0", 32'(O_Count), 32'd0);
        chk("p1_busy0",  32'(O_Busy),  32'd0);
        tick();
        chk("p1_term_pulse", 32'(O_Term), 32'd0);
        chk("p1_err",        32'(O_Err),  32'd0);

        // Fill, refuse a 9th issue
        for (int i = 0; i < 8; i++) push(mpu_issue_no_t'(8'h10 + i));
        chk("fill_count", 32'(O_Count), 32'd8);
        chk("fill_nack0", 32'(O_Nack),  32'd0);
        push(8'h99);
        chk("ovf_nack",  32'(O_Nack),  32'd1);
        chk("ovf_count", 32'(O_Count), 32'd8);
        tick();
        chk("ovf_nack_pulse", 32'(O_Nack), 32'd0);

        // Full queue, simultaneous push and term
        I_Req = 1'b1; I_En_Exe = 1'b1; I_IssueNo = 8'h50; I_Term = 1'b1;
        tick();
        idle();
        chk("fp_nack",  32'(O_Nack),    32'd0);
        chk("fp_count", 32'(O_Count),   32'd8);
        chk("fp_term",  32'(O_Term),    32'd1);
        chk("fp_no",    32'(O_IssueNo), 32'h10);
        for (int i = 1; i < 8; i++) term_expect("fp_drain", mpu_issue_no_t'(8'h10 + i));
        term_expect("fp_last", 8'h50);
        chk("fp_count0", 32'(O_Count), 32'd0);
        chk("fp_err",    32'(O_Err),   32'd0);

        // Term on empty
        I_Term = 1'b1;
        tick();
        idle();
        chk("emp_err",   32'(O_Err),   32'd1);
        chk("emp_term",  32'(O_Term),  32'd0);
        chk("emp_count", 32'(O_Count), 32'd0);
        // Empty queue, simultaneous push and term: no bypass
        I_Req = 1'b1; I_En_Exe = 1'b1; I_IssueNo = 8'h21; I_Term = 1'b1;
        tick();
        idle();
        chk("eb_term",  32'(O_Term),  32'd0);
        chk("eb_count", 32'(O_Count), 32'd1);
        term_expect("eb_commit", 8'h21);
        chk("eb_err_sticky", 32'(O_Err), 32'd1);
        push(8'h22);
        term_expect("emp_after", 8'h22);

        // Disabled request is ignored
        I_Req = 1'b1; I_En_Exe = 1'b0; I_IssueNo = 8'h77;
        tick();
        idle();
        tick();
        chk("dis_count", 32'(O_Count), 32'd0);
        chk("dis_nack",  32'(O_Nack),  32'd0);
        chk("dis_busy",  32'(O_Busy),  32'd0);

        // Reset mid-operation discards outstanding issues
        push(8'h31); push(8'h32);
        reset = 1'b0;
        tick();
        chk("mid_count", 32'(O_Count), 32'd0);
        chk("mid_err",   32'(O_Err),   32'd0);
        reset = 1'b1;
        tick();
        push(8'h41);
        term_expect("mid_after", 8'h41);

        // Watchdog
        push(8'h60);
`ifdef TPU_COMMIT_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 15) chk("wd_pre", 32'(O_Timeout), 32'd0);
        end
        tick();
        chk("wd_fire", 32'(O_Timeout), 32'd1);
        term_expect("wd_pop", 8'h60);
        tick();
        chk("wd_sticky", 32'(O_Timeout), 32'd1);
        reset = 1'b0;
        tick();
        chk("wd_reset", 32'(O_Timeout), 32'd0);
        reset = 1'b1;
        tick();
`else
        repeat (20) tick();
        chk("wd_absent", 32'(O_Timeout), 32'd0);
        term_expect("wd_pop", 8'h60);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
